// File: rtl/cvxif_pkg.sv
// CV-X-IF interface types shared by the core side and coprocessor blocks.
package cvxif_pkg;

  localparam int unsigned X_ID_WIDTH = 3;
  localparam int unsigned X_RFW      = 32;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic                  commit_kill;
  } x_commit_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [X_RFW-1:0]      data;
    logic [4:0]            rd;
    logic                  we;
    logic                  exc;
    logic [5:0]            exccode;
  } x_result_t;

endpackage

// File: rtl/cvxif_sched_pkg.sv
// Types and constants for the CV-X-IF commit scheduler.
package cvxif_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUED,
    COMMITTED,
    KILLED,
    OUT
  } sched_state_e;

  // Bit positions of the individual protocol-error sources.
  localparam int unsigned ERR_ISSUE  = 0;
  localparam int unsigned ERR_COMMIT = 1;
  localparam int unsigned ERR_EU     = 2;
  localparam int unsigned ERR_W      = 3;

endpackage

// File: rtl/cvxif_sched_entry.sv
// Per-ID lifecycle tracker: issue -> commit/kill -> EU result -> delivery.
module cvxif_sched_entry
  import cvxif_sched_pkg::*;
#(
  parameter bit ResultReg = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         issue_i,
  input  logic         commit_i,
  input  logic         kill_i,
  input  logic         eu_hs_i,
  input  logic         out_hs_i,
  output sched_state_e state_o,
  output logic         issue_err_o,
  output logic         commit_err_o
);

  sched_state_e state_q, state_d;
  logic         to_idle;

  always_comb begin
    state_d      = state_q;
    to_idle      = 1'b0;
    issue_err_o  = 1'b0;
    commit_err_o = commit_i && (state_q != ISSUED);
    case (state_q)
      IDLE: ;
      ISSUED: begin
        if (commit_i) state_d = kill_i ? KILLED : COMMITTED;
      end
      COMMITTED: begin
        // Without an output register the result leaves in the EU handshake cycle.
        if (eu_hs_i) begin
          if (ResultReg) begin
            state_d = OUT;
          end else begin
            state_d = IDLE;
            to_idle = 1'b1;
          end
        end
      end
      KILLED: begin
        if (eu_hs_i) begin
          state_d = IDLE;
          to_idle = 1'b1;
        end
      end
      OUT: begin
        if (out_hs_i) begin
          state_d = IDLE;
          to_idle = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A freeing entry may be re-issued in the same cycle.
    if (issue_i) begin
      if ((state_q == IDLE) || to_idle) state_d = ISSUED;
      else                              issue_err_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/cvxif_commit_scheduler.sv
// Holds EU results until the core commits their ID; drops killed results.
// Optional performance counters enabled by defining CVXIF_SCHED_PERF_EN.
module cvxif_commit_scheduler
  import cvxif_pkg::*;
  import cvxif_sched_pkg::*;
#(
  parameter int unsigned NbIds     = 2**X_ID_WIDTH,
  parameter bit          ResultReg = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  issue_accept_i,
  input  logic [X_ID_WIDTH-1:0] issue_id_i,
  output logic                  issue_id_free_o,
  input  logic                  commit_valid_i,
  input  x_commit_t             commit_i,
  input  logic                  eu_valid_i,
  output logic                  eu_ready_o,
  input  x_result_t             eu_result_i,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output x_result_t             result_o,
  output logic                  busy_o,
  output logic                  proto_err_o
`ifdef CVXIF_SCHED_PERF_EN
  ,
  output logic [31:0]           perf_commit_cnt_o,
  output logic [31:0]           perf_kill_cnt_o,
  output logic [31:0]           perf_stall_cnt_o
`endif
);

  sched_state_e     state [NbIds];
  sched_state_e     eu_state;
  logic [NbIds-1:0] issue_sel, commit_sel, eu_hs_sel, out_hs_sel;
  logic [NbIds-1:0] issue_err, commit_err, busy_vec;
  logic             eu_hs, eu_load, eu_err, out_room, out_hs;
  logic [ERR_W-1:0] err_vec;
  logic             proto_err_q, proto_err_d;

  for (genvar i = 0; i < NbIds; i++) begin : g_entry
    assign issue_sel[i]  = issue_accept_i && (issue_id_i == X_ID_WIDTH'(i));
    assign commit_sel[i] = commit_valid_i && (commit_i.id == X_ID_WIDTH'(i));
    assign eu_hs_sel[i]  = eu_hs && (eu_result_i.id == X_ID_WIDTH'(i));
    assign out_hs_sel[i] = out_hs && (result_o.id == X_ID_WIDTH'(i));
    assign busy_vec[i]   = (state[i] != IDLE);

    cvxif_sched_entry #(
      .ResultReg (ResultReg)
    ) u_entry (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .issue_i      (issue_sel[i]),
      .commit_i     (commit_sel[i]),
      .kill_i       (commit_i.commit_kill),
      .eu_hs_i      (eu_hs_sel[i]),
      .out_hs_i     (out_hs_sel[i]),
      .state_o      (state[i]),
      .issue_err_o  (issue_err[i]),
      .commit_err_o (commit_err[i])
    );
  end

  assign eu_state        = state[eu_result_i.id];
  assign issue_id_free_o = (state[issue_id_i] == IDLE);
  assign busy_o          = |busy_vec;

  always_comb begin
    eu_ready_o = 1'b0;
    case (eu_state)
      KILLED:    eu_ready_o = 1'b1;
      COMMITTED: eu_ready_o = out_room;
      default:   eu_ready_o = 1'b0;
    endcase
  end

  assign eu_hs   = eu_valid_i && eu_ready_o;
  assign eu_load = eu_hs && (eu_state == COMMITTED);
  // An EU result for an ID with nothing outstanding breaks the protocol.
  assign eu_err  = eu_valid_i && ((eu_state == IDLE) || (eu_state == OUT));

  if (ResultReg) begin : g_out_reg
    logic      out_valid_q, out_valid_d;
    x_result_t out_q, out_d;

    always_comb begin
      out_valid_d = out_valid_q;
      out_d       = out_q;
      if (out_hs) out_valid_d = 1'b0;
      if (eu_load) begin
        out_valid_d = 1'b1;
        out_d       = eu_result_i;
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        out_valid_q <= 1'b0;
        out_q       <= '0;
      end else begin
        out_valid_q <= out_valid_d;
        out_q       <= out_d;
      end
    end

    assign out_room       = !out_valid_q || result_ready_i;
    assign out_hs         = out_valid_q && result_ready_i;
    assign result_valid_o = out_valid_q;
    assign result_o       = out_q;
  end else begin : g_out_comb
    assign out_room       = result_ready_i;
    assign out_hs         = 1'b0;
    assign result_valid_o = eu_valid_i && (eu_state == COMMITTED);
    assign result_o       = eu_result_i;
  end

  always_comb begin
    err_vec             = '0;
    err_vec[ERR_ISSUE]  = |issue_err;
    err_vec[ERR_COMMIT] = |commit_err;
    err_vec[ERR_EU]     = eu_err;
    proto_err_d         = proto_err_q || (|err_vec);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) proto_err_q <= 1'b0;
    else         proto_err_q <= proto_err_d;
  end

  assign proto_err_o = proto_err_q;

`ifdef CVXIF_SCHED_PERF_EN
  logic [31:0] perf_commit_q, perf_commit_d;
  logic [31:0] perf_kill_q, perf_kill_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_commit_d = perf_commit_q;
    perf_kill_d   = perf_kill_q;
    perf_stall_d  = perf_stall_q;
    if (commit_valid_i && !commit_i.commit_kill) perf_commit_d = perf_commit_q + 32'd1;
    if (commit_valid_i && commit_i.commit_kill)  perf_kill_d   = perf_kill_q + 32'd1;
    if (eu_valid_i && !eu_ready_o)               perf_stall_d  = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      perf_commit_q <= '0;
      perf_kill_q   <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_commit_q <= perf_commit_d;
      perf_kill_q   <= perf_kill_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_commit_cnt_o = perf_commit_q;
  assign perf_kill_cnt_o   = perf_kill_q;
  assign perf_stall_cnt_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_cvxif_commit_scheduler.sv
// Directed bench for cvxif_commit_scheduler (default build, ResultReg=1).
module tb_cvxif_commit_scheduler;
  import cvxif_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_ni;
  logic                  issue_accept;
  logic [X_ID_WIDTH-1:0] issue_id;
  logic                  issue_id_free;
  logic                  commit_valid;
  x_commit_t             commit;
  logic                  eu_valid;
  logic                  eu_ready;
  x_result_t             eu_result;
  logic                  result_valid;
  logic                  result_ready;
  x_result_t             result;
  logic                  busy;
  logic                  proto_err;
`ifdef CVXIF_SCHED_PERF_EN
  logic [31:0]           perf_commit, perf_kill, perf_stall;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  x_result_t exp_r;

  always #5 clk = ~clk;

  cvxif_commit_scheduler dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .issue_accept_i  (issue_accept),
    .issue_id_i      (issue_id),
    .issue_id_free_o (issue_id_free),
    .commit_valid_i  (commit_valid),
    .commit_i        (commit),
    .eu_valid_i      (eu_valid),
    .eu_ready_o      (eu_ready),
    .eu_result_i     (eu_result),
    .result_valid_o  (result_valid),
    .result_ready_i  (result_ready),
    .result_o        (result),
    .busy_o          (busy),
    .proto_err_o     (proto_err)
`ifdef CVXIF_SCHED_PERF_EN
    ,
    .perf_commit_cnt_o (perf_commit),
    .perf_kill_cnt_o   (perf_kill),
    .perf_stall_cnt_o  (perf_stall)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic x_result_t mk_res(input logic [X_ID_WIDTH-1:0] id, input logic [31:0] data);
    x_result_t r;
    r.id      = id;
    r.data    = data;
    r.rd      = 5'd10;
    r.we      = data[0];
    r.exc     = 1'b0;
    r.exccode = data[7:2];
    return r;
  endfunction

  task automatic drv_issue(input logic v, input logic [X_ID_WIDTH-1:0] id);
    issue_accept = v;
    issue_id     = id;
  endtask

  task automatic drv_commit(input logic v, input logic [X_ID_WIDTH-1:0] id, input logic kill);
    commit_valid       = v;
    commit.id          = id;
    commit.commit_kill = kill;
  endtask

  task automatic drv_eu(input logic v, input logic [X_ID_WIDTH-1:0] id, input logic [31:0] data);
    eu_valid  = v;
    eu_result = mk_res(id, data);
  endtask

  initial begin
    rst_ni       = 1'b0;
    result_ready = 1'b0;
    drv_issue(1'b0, 3'd0);
    drv_commit(1'b0, 3'd0, 1'b0);
    drv_eu(1'b0, 3'd0, 32'h0);
    tick();
    tick();
    settle();
    chk("rst_result_valid", 64'(result_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_eu_ready", 64'(eu_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_proto_err", 64'(proto_err), 64'd0);
    chk("rst_id_free", 64'(issue_id_free), 64'd1);
    rst_ni = 1'b1;

    // Basic commit-then-result flow on id 3
    drv_issue(1'b1, 3'd3);
    settle();
    chk("t1_free_before", 64'(issue_id_free), 64'd1);
    tick();
    drv_issue(1'b0, 3'd3);
    settle();
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_free_after", 64'(issue_id_free), 64'd0);
    drv_commit(1'b1, 3'd3, 1'b0);
    tick();
    drv_commit(1'b0, 3'd0, 1'b0);
    drv_eu(1'b1, 3'd3, 32'h15);
    settle();
    chk("t1_eu_ready", 64'(eu_ready), 64'd1);
    chk("t1_no_early_valid", 64'(result_valid), 64'd0);
    tick();
    drv_eu(1'b0, 3'd0, 32'h0);
    result_ready = 1'b1;
    settle();
    exp_r = mk_res(3'd3, 32'h15);
    chk("t1_result_valid", 64'(result_valid), 64'd1);
    chk("t1_result", 64'(result), 64'(exp_r));
    tick();
    result_ready = 1'b0;
    settle();
    chk("t1_valid_drop", 64'(result_valid), 64'd0);
    chk("t1_busy_drop", 64'(busy), 64'd0);
    chk("t1_free_again", 64'(issue_id_free), 64'd1);

    // EU result arrives before commit: stall until committed
    drv_issue(1'b1, 3'd2);
    tick();
    drv_issue(1'b0, 3'd2);
    drv_eu(1'b1, 3'd2, 32'h22);
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("t2_stall", 64'(eu_ready), 64'd0);
      tick();
    end
    drv_commit(1'b1, 3'd2, 1'b0);
    settle();
    chk("t2_commit_cycle_stall", 64'(eu_ready), 64'd0);
    tick();
    drv_commit(1'b0, 3'd0, 1'b0);
    settle();
    chk("t2_accept", 64'(eu_ready), 64'd1);
    chk("t2_no_valid_yet", 64'(result_valid), 64'd0);
    tick();
    drv_eu(1'b0, 3'd0, 32'h0);
    result_ready = 1'b1;
    settle();
    exp_r = mk_res(3'd2, 32'h22);
    chk("t2_result_valid", 64'(result_valid), 64'd1);
    chk("t2_result", 64'(result), 64'(exp_r));
    tick();
    result_ready = 1'b0;
    settle();
    chk("t2_busy_drop", 64'(busy), 64'd0);

    // Killed result is dropped; re-issue in the drop cycle is legal
    drv_issue(1'b1, 3'd1);
    tick();
    drv_issue(1'b0, 3'd1);
    drv_commit(1'b1, 3'd1, 1'b1);
    tick();
    drv_commit(1'b0, 3'd0, 1'b0);
    drv_eu(1'b1, 3'd1, 32'h99);
    drv_issue(1'b1, 3'd1);
    settle();
    chk("t3_kill_ready", 64'(eu_ready), 64'd1);
    chk("t3_killed_busy", 64'(busy), 64'd1);
    chk("t3_killed_not_free", 64'(issue_id_free), 64'd0);
    tick();
    drv_eu(1'b0, 3'd0, 32'h0);
    drv_issue(1'b0, 3'd1);
    settle();
    chk("t3_no_result", 64'(result_valid), 64'd0);
    chk("t3_reissued_busy", 64'(busy), 64'd1);
    chk("t3_reissued_not_free", 64'(issue_id_free), 64'd0);
    chk("t3_no_proto_err", 64'(proto_err), 64'd0);
    drv_commit(1'b1, 3'd1, 1'b1);
    tick();
    drv_commit(1'b0, 3'd0, 1'b0);
    drv_eu(1'b1, 3'd1, 32'h77);
    settle();
    chk("t3_kill2_ready", 64'(eu_ready), 64'd1);
    tick();
    drv_eu(1'b0, 3'd0, 32'h0);
    settle();
    chk("t3_busy_drop", 64'(busy), 64'd0);
    chk("t3_still_no_result", 64'(result_valid), 64'd0);

    // Back-pressure with two committed IDs
    drv_issue(1'b1, 3'd4);
    tick();
    drv_issue(1'b1, 3'd5);
    drv_commit(1'b1, 3'd4, 1'b0);
    tick();
    drv_issue(1'b0, 3'd5);
    drv_commit(1'b1, 3'd5, 1'b0);
    tick();
    drv_commit(1'b0, 3'd0, 1'b0);
    drv_eu(1'b1, 3'd4, 32'h44);
    settle();
    chk("t4_eu4_ready", 64'(eu_ready), 64'd1);
    tick();
    drv_eu(1'b1, 3'd5, 32'h55);
    exp_r = mk_res(3'd4, 32'h44);
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("t4_hold_valid", 64'(result_valid), 64'd1);
      chk("t4_hold_result", 64'(result), 64'(exp_r));
      chk("t4_eu5_stalled", 64'(eu_ready), 64'd0);
      tick();
    end
    result_ready = 1'b1;
    settle();
    chk("t4_eu5_ready", 64'(eu_ready), 64'd1);
    chk("t4_result4", 64'(result), 64'(exp_r));
    tick();
    drv_eu(1'b0, 3'd0, 32'h0);
    settle();
    exp_r = mk_res(3'd5, 32'h55);
    chk("t4_valid5", 64'(result_valid), 64'd1);
    chk("t4_result5", 64'(result), 64'(exp_r));
    tick();
    result_ready = 1'b0;
    settle();
    chk("t4_valid_drop", 64'(result_valid), 64'd0);
    chk("t4_busy_drop", 64'(busy), 64'd0);
    chk("t4_no_proto_err", 64'(proto_err), 64'd0);

    // Protocol errors: double issue and commit on an idle ID
    drv_issue(1'b1, 3'd6);
    tick();
    drv_issue(1'b0, 3'd6);
    settle();
    chk("t5_pre_err", 64'(proto_err), 64'd0);
    drv_issue(1'b1, 3'd6);
    drv_commit(1'b1, 3'd7, 1'b0);
    tick();
    drv_issue(1'b0, 3'd6);
    drv_commit(1'b0, 3'd0, 1'b0);
    settle();
    chk("t5_proto_err", 64'(proto_err), 64'd1);
    chk("t5_id6_still_issued", 64'(issue_id_free), 64'd0);
    drv_issue(1'b0, 3'd7);
    settle();
    chk("t5_id7_still_idle", 64'(issue_id_free), 64'd1);
    tick();
    settle();
    chk("t5_err_sticky", 64'(proto_err), 64'd1);

    // Reset with a pending result in the output register
    drv_issue(1'b1, 3'd0);
    tick();
    drv_issue(1'b0, 3'd0);
    drv_commit(1'b1, 3'd0, 1'b0);
    tick();
    drv_commit(1'b0, 3'd0, 1'b0);
    drv_eu(1'b1, 3'd0, 32'hA5);
    settle();
    chk("t6_eu_ready", 64'(eu_ready), 64'd1);
    tick();
    drv_eu(1'b0, 3'd0, 32'h0);
    settle();
    chk("t6_pending", 64'(result_valid), 64'd1);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    settle();
    chk("t6_valid_cleared", 64'(result_valid), 64'd0);
    chk("t6_result_cleared", 64'(result), 64'd0);
    chk("t6_busy_cleared", 64'(busy), 64'd0);
    chk("t6_err_cleared", 64'(proto_err), 64'd0);
`ifdef CVXIF_SCHED_PERF_EN
    chk("t6_perf_commit", 64'(perf_commit), 64'd0);
    chk("t6_perf_kill", 64'(perf_kill), 64'd0);
    chk("t6_perf_stall", 64'(perf_stall), 64'd0);
`endif
    tick();
    settle();
    chk("t6_no_late_result", 64'(result_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
